// File: rtl/act_lut_writer_if.sv
// Load, lookup and result signals of the activation LUT, bundled for the block and its driver.
// The checksum signal exists only when ACT_LUT_CHECKSUM_EN is defined.
interface act_lut_writer_if;
    logic              load_start;
    logic              load_valid;
    logic              load_ready;
    logic signed [7:0] load_data;
    logic              table_valid;
    logic              z_valid;
    logic              z_ready;
    logic signed [7:0] z_value;
    logic              a_valid;
    logic signed [7:0] a;
`ifdef ACT_LUT_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    modport slave (
        input  load_start, load_valid, load_data, z_valid, z_value,
        output load_ready, table_valid, z_ready, a_valid, a
`ifdef ACT_LUT_CHECKSUM_EN
        , output checksum
`endif
    );

    modport master (
        output load_start, load_valid, load_data, z_valid, z_value,
        input  load_ready, table_valid, z_ready, a_valid, a
`ifdef ACT_LUT_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/act_lut_writer.sv
// 16-entry signed activation LUT: streamed load, then piecewise-linear lookup with 1-cycle latency.
// Optional ACT_LUT_CHECKSUM_EN adds a modulo-256 sum of the entries loaded since the last load_start.
module act_lut_writer (
    input  logic             clk,
    input  logic             rst,
    act_lut_writer_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, LOAD, ACTIVE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wr_ptr_reg, wr_ptr_next;
    logic              table_valid_reg, table_valid_next;
    logic              a_valid_reg;
    logic signed [7:0] a_reg;
    logic signed [7:0] tbl_mem [16];

    logic              load_ready_int, z_ready_int;
    logic              load_fire, z_fire;

    logic [3:0]         address, remaining, next_idx;
    logic signed [7:0]  base_val, next_val;
    logic signed [8:0]  diff;
    logic signed [12:0] prod;
    logic signed [7:0]  interp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= EMPTY;
            wr_ptr_reg      <= 4'd0;
            table_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            table_valid_reg <= table_valid_next;
        end
    end

    // Handshake readiness is suppressed while load_start or rst is high so neither side can transfer.
    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        table_valid_next = table_valid_reg;
        load_ready_int   = 1'b0;
        z_ready_int      = 1'b0;
        if (!rst && !bus.load_start) begin
            load_ready_int = (state_reg == LOAD);
            z_ready_int    = (state_reg == ACTIVE);
        end
        load_fire = load_ready_int && bus.load_valid;
        z_fire    = z_ready_int && bus.z_valid;
        if (bus.load_start) begin
            state_next       = LOAD;
            wr_ptr_next      = 4'd0;
            table_valid_next = 1'b0;
        end else if (load_fire) begin
            wr_ptr_next = wr_ptr_reg + 4'd1;
            if (wr_ptr_reg == 4'd15) begin
                state_next       = ACTIVE;
                table_valid_next = 1'b1;
            end
        end
    end

    // Table storage is deliberately not reset; table_valid gates its use.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            tbl_mem[wr_ptr_reg] <= bus.load_data;
        end
    end

    // The top segment has no successor, so it interpolates against itself (flat).
    assign address   = bus.z_value[7:4];
    assign remaining = bus.z_value[3:0];
    assign next_idx  = (address == 4'd15) ? address : address + 4'd1;
    assign base_val  = tbl_mem[address];
    assign next_val  = tbl_mem[next_idx];
    assign diff      = 9'(next_val) - 9'(base_val);
    assign prod      = 13'(diff) * 13'($signed({1'b0, remaining}));
    assign interp    = 8'(13'(base_val) + (prod >>> 4));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_reg <= 1'b0;
            a_reg       <= 8'sd0;
        end else begin
            a_valid_reg <= z_fire && !bus.load_start;
            if (z_fire) begin
                a_reg <= interp;
            end
        end
    end

`ifdef ACT_LUT_CHECKSUM_EN
    logic [7:0] checksum_reg;

    always_ff @(posedge clk) begin
        if (rst || bus.load_start) begin
            checksum_reg <= 8'd0;
        end else if (load_fire) begin
            checksum_reg <= checksum_reg + bus.load_data;
        end
    end

    assign bus.checksum = checksum_reg;
`endif

    assign bus.load_ready  = load_ready_int;
    assign bus.z_ready     = z_ready_int;
    assign bus.table_valid = table_valid_reg;
    assign bus.a_valid     = a_valid_reg;
    assign bus.a           = a_reg;
endmodule

// File: doc/act_lut_writer.md
ACT_LUT_WRITER -- requirements
Module: act_lut_writer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port load_start, input, 1 bit: begin (re)loading the table from entry 0.
REQ-004 SHALL have port load_valid, input, 1 bit: load_data valid.
REQ-005 SHALL have port load_ready, output, 1 bit: block accepts load_data.
REQ-006 SHALL have port load_data, input, signed 8 bits: next table entry.
REQ-007 SHALL have port table_valid, output, 1 bit: all 16 entries loaded.
REQ-008 SHALL have port z_valid, input, 1 bit: z_value valid.
REQ-009 SHALL have port z_ready, output, 1 bit: block accepts z_value.
REQ-010 SHALL have port z_value, input, signed 8 bits: activation input.
REQ-011 SHALL have port a_valid, output, 1 bit: a holds a result.
REQ-012 SHALL have port a, output, signed 8 bits: interpolated activation.
REQ-013 SHALL have port checksum, output, 8 bits: present only with ACT_LUT_CHECKSUM_EN.

Function
REQ-014 SHALL hold a 16 x 8-bit signed table and a 4-bit write pointer wr_ptr.
REQ-015 SHALL implement FSM states EMPTY, LOAD, ACTIVE.
REQ-016 SHALL transition to LOAD from any state when load_start=1; wr_ptr<=0, table_valid<=0, a_valid<=0.
REQ-017 SHALL drive load_ready=1 only in LOAD and only when load_start=0.
REQ-018 SHALL, in LOAD, write load_data to entry wr_ptr on load_valid&&load_ready and increment wr_ptr.
REQ-019 SHALL, on the write to entry 15, go to ACTIVE and set table_valid=1 on the next cycle; wr_ptr wraps to 0.
REQ-020 SHALL drive z_ready=1 only in ACTIVE with load_start=0.
REQ-021 SHALL, on z_valid&&z_ready, use address=z_value[7:4] (unsigned) and remaining=z_value[3:0] (unsigned, 0..15).
REQ-022 SHALL define base=T[address] and next=T[address+1]; for address=15, next=T[15] (no wrap).
REQ-023 SHALL compute a = base + ((next-base)*remaining) >>> 4, using 9-bit difference and 13-bit product, arithmetic shift, truncated to 8 bits.
REQ-024 SHALL register a and a_valid with latency 1: accepted on edge N, valid after edge N+1.
REQ-025 SHALL hold a_valid=1 for exactly one cycle per accepted z_value; back-to-back inputs give back-to-back results.
REQ-026 SHALL ignore z_valid outside ACTIVE and ignore load_valid outside LOAD.
REQ-027 SHALL give load_start priority over a simultaneous load_valid or z_valid (neither accepted that cycle).

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter EMPTY, set wr_ptr=0, table_valid=0, a_valid=0, a=0, load_ready=0, z_ready=0.
REQ-029 SHALL leave table contents unchanged on reset; entries are unusable until a complete reload.
REQ-030 SHALL give rst priority over load_start and all handshakes; a reset mid-load discards the partial load.

Configuration
REQ-031 SHALL, with ACT_LUT_CHECKSUM_EN defined, include output checksum: 8-bit modulo-256 sum of entries accepted since the last load_start; cleared to 0 by rst and by load_start.
REQ-032 SHALL, without ACT_LUT_CHECKSUM_EN, omit the checksum port and accumulator; all other behaviour is identical.

Verification
REQ-033 Reset, then load 16 entries T[i]=i*8 -> table_valid=1 one cycle after the 16th write; load_ready=0 afterward.
REQ-034 With that table, z_value=8'h24 -> base=16, next=24, remaining=4; a=18 one cycle after acceptance, a_valid pulses once.
REQ-035 z_value=8'hF7 with T[15]=120 -> a=120 (address-15 clamp).
REQ-036 load_valid toggling 1/0 during load -> exactly 16 accepted writes; a lookup of z_value=8'h10 returns T[1].
REQ-037 rst asserted after 7 writes -> EMPTY, table_valid=0, z_ready=0; a later load_start plus 16 writes restores ACTIVE.
REQ-038 With ACT_LUT_CHECKSUM_EN, entries 0..15 each 8'h11 -> checksum=8'h10; load_start clears it to 0.
